// File: rtl/axis_mem2m.sv
// Drains one FFT frame from mem0 port A onto an AXI4-Stream master; tvalid rises two cycles after start.
// Backpressure gates the RAM enable so the registered RAM output holds the beat; no skid buffer.
module axis_mem2m #(
    parameter int FFT_SIZE   = 4096,
    parameter int DATA_WIDTH = 64,
    parameter int BIT_REV    = 0,
    parameter int ADDR_WIDTH = $clog2(FFT_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  axis_tx,
    output logic                  done,
    output logic                  axis_mem2m_clken,
    output logic [ADDR_WIDTH-1:0] axis_mem2m_raddr,
    input  logic [DATA_WIDTH-1:0] axis_mem2m_rdata,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(FFT_SIZE - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH-1:0]   cnt_rev;
    logic                    adv;
    logic                    issue;

    assign adv   = !tvalid_q || m_axis_tready;
    assign issue = (state_q == RUN) && adv;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        done_d   = 1'b0;
        case (state_q)
            // A start landing on the done pulse belongs to the frame just finished.
            IDLE: begin
                if (start && !done_q) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (adv) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (adv) begin
            tvalid_d = issue;
            tlast_d  = issue && (cnt_q == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        cnt_rev = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            cnt_rev[i] = cnt_q[ADDR_WIDTH-1-i];
        end
    end

    assign axis_mem2m_raddr = (BIT_REV != 0) ? cnt_rev : cnt_q;
    assign axis_mem2m_clken = issue;
    assign axis_tx          = (state_q != IDLE);
    assign done             = done_q;
    assign m_axis_tvalid    = tvalid_q;
    assign m_axis_tlast     = tlast_q;
    assign m_axis_tdata     = axis_mem2m_rdata;

endmodule

// File: tb/tb_axis_mem2m.sv
// Bench for axis_mem2m with FFT_SIZE=8: vector table, hand sequences and random-tready frames
// checked against a beat-order scoreboard and AXI stability rules.
module tb_axis_mem2m;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        tready = 1'b0;

    logic        tx0, done0, clken0, vld0, last0;
    logic [2:0]  raddr0;
    logic [63:0] rdata0 = '0, dat0;
    logic        tx1, done1, clken1, vld1, last1;
    logic [2:0]  raddr1;
    logic [63:0] rdata1 = '0, dat1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axis_mem2m #(.FFT_SIZE(N), .DATA_WIDTH(64), .BIT_REV(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .axis_tx(tx0), .done(done0),
        .axis_mem2m_clken(clken0), .axis_mem2m_raddr(raddr0), .axis_mem2m_rdata(rdata0),
        .m_axis_tdata(dat0), .m_axis_tvalid(vld0), .m_axis_tready(tready), .m_axis_tlast(last0)
    );

    axis_mem2m #(.FFT_SIZE(N), .DATA_WIDTH(64), .BIT_REV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .axis_tx(tx1), .done(done1),
        .axis_mem2m_clken(clken1), .axis_mem2m_raddr(raddr1), .axis_mem2m_rdata(rdata1),
        .m_axis_tdata(dat1), .m_axis_tvalid(vld1), .m_axis_tready(tready), .m_axis_tlast(last1)
    );

    // mem0 preloaded with word[i] = 0x100 + i, one-cycle registered read
    always @(posedge clk) begin
        if (clken0) rdata0 <= 64'h100 + 64'(raddr0);
        if (clken1) rdata1 <= 64'h100 + 64'(raddr1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int rev3(input int i);
        return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
    endfunction

    // Scoreboard for dut0: beats must arrive in order 0x100.., tlast on the 8th,
    // done exactly one cycle after the last handshake, stalled beats held stable.
    int          sb_beat = 0;
    logic        sb_done_exp = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_dat = '0;
    logic        prev_last = 1'b0;
    logic [2:0]  prev_raddr = '0;

    always @(negedge clk) begin
        if (rst) begin
            sb_beat     = 0;
            sb_done_exp = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            check("sb_done", done0, sb_done_exp);
            sb_done_exp = 1'b0;
            if (prev_stall) begin
                check("stall_vld", vld0, 1'b1);
                check("stall_dat", dat0, prev_dat);
                check("stall_last", last0, prev_last);
                check("stall_raddr", 64'(raddr0), 64'(prev_raddr));
            end
            if (vld0 && !tready) check("stall_clken", clken0, 1'b0);
            if (!tx0) check("idle_vld", vld0, 1'b0);
            if (vld0 && tready) begin
                check("sb_dat", dat0, 64'h100 + 64'(sb_beat));
                check("sb_last", last0, sb_beat == N - 1);
                if (sb_beat == N - 1) begin
                    sb_beat     = 0;
                    sb_done_exp = 1'b1;
                end else begin
                    sb_beat++;
                end
            end
            prev_stall = vld0 && !tready;
            prev_dat   = dat0;
            prev_last  = last0;
            prev_raddr = raddr0;
        end
    end

    // mode 0: tready high, 1: toggling, 2: random
    task automatic run_frame(input int mode, output int beats, output int dones);
        beats = 0;
        dones = 0;
        for (int c = 0; c < 200 && dones == 0; c++) begin
            @(posedge clk); #1;
            start0 = (c == 0);
            case (mode)
                0:       tready = 1'b1;
                1:       tready = c[0];
                default: tready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (vld0 && tready) beats++;
            if (done0) dones++;
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        tready = 1'b1;
    endtask

    typedef struct {
        logic        start;
        logic        rdy;
        logic        vld;
        logic [63:0] dat;
        logic        last;
        logic        done;
        logic        tx;
        logic        clken;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int beats, dones, k, nd;

        // continuous frame: beats on cycles 2..9, done on cycle 10
        for (int c = 0; c < 12; c++) begin
            tbl[c].start = (c == 0);
            tbl[c].rdy   = 1'b1;
            tbl[c].vld   = (c >= 2 && c <= 9);
            tbl[c].dat   = 64'h100 + 64'(c - 2);
            tbl[c].last  = (c == 9);
            tbl[c].done  = (c == 10);
            tbl[c].tx    = (c >= 1 && c <= 9);
            tbl[c].clken = (c >= 1 && c <= 8);
        end

        #2 rst = 1'b1;
        #1;
        check("rst_vld", vld0, 1'b0);
        check("rst_last", last0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_tx", tx0, 1'b0);
        check("rst_clken", clken0, 1'b0);
        check("rst_vld1", vld1, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tready = 1'b1;
        @(negedge clk);
        check("post_rst_tx", tx0, 1'b0);

        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            start0 = tbl[c].start;
            tready = tbl[c].rdy;
            @(negedge clk);
            check($sformatf("vec%0d_vld", c), vld0, tbl[c].vld);
            if (tbl[c].vld) check($sformatf("vec%0d_dat", c), dat0, tbl[c].dat);
            check($sformatf("vec%0d_last", c), last0, tbl[c].last);
            check($sformatf("vec%0d_done", c), done0, tbl[c].done);
            check($sformatf("vec%0d_tx", c), tx0, tbl[c].tx);
            check($sformatf("vec%0d_clken", c), clken0, tbl[c].clken);
        end

        // backpressure: 0x103 stalled for cycles 5..7
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            start0 = (c == 0);
            tready = !(c >= 5 && c <= 7);
            @(negedge clk);
            if (c >= 5 && c <= 7) begin
                check("bp_dat", dat0, 64'h103);
                check("bp_vld", vld0, 1'b1);
                check("bp_clken", clken0, 1'b0);
                check("bp_raddr", 64'(raddr0), 64'd4);
            end
            if (c == 12) check("bp_last_dat", dat0, 64'h107);
            if (c == 12) check("bp_last", last0, 1'b1);
            if (c == 13) check("bp_done", done0, 1'b1);
        end

        run_frame(1, beats, dones);
        check("alt_beats", 64'(beats), 64'd8);
        check("alt_done", 64'(dones), 64'd1);

        // bit-reversed read order on dut1
        k = 0;
        nd = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            start1 = (c == 0);
            tready = 1'b1;
            @(negedge clk);
            if (vld1) begin
                check($sformatf("brev%0d_dat", k), dat1, 64'h100 + 64'(rev3(k)));
                check($sformatf("brev%0d_last", k), last1, k == N - 1);
                k++;
            end
            if (done1) nd++;
        end
        check("brev_beats", 64'(k), 64'd8);
        check("brev_done", 64'(nd), 64'd1);

        // spurious starts mid-frame, in DRAIN and in the done cycle; next-cycle start accepted
        nd = 0;
        for (int c = 0; c < 26; c++) begin
            @(posedge clk); #1;
            start0 = (c == 0 || c == 4 || c == 9 || c == 10 || c == 11);
            tready = 1'b1;
            @(negedge clk);
            if (c == 10) check("sp_done1", done0, 1'b1);
            if (c == 11) check("sp_ignored_tx", tx0, 1'b0);
            if (c == 12) check("sp_second_tx", tx0, 1'b1);
            if (c == 21) check("sp_done2", done0, 1'b1);
            if (done0) nd++;
        end
        check("sp_frames", 64'(nd), 64'd2);

        // reset mid-frame after beat 0x103 has been accepted
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            start0 = (c == 0);
            tready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mr_vld", vld0, 1'b0);
        check("mr_tx", tx0, 1'b0);
        check("mr_clken", clken0, 1'b0);
        check("mr_last", last0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done0) nd++;
        end
        check("mr_no_done", 64'(nd), 64'd0);
        run_frame(0, beats, dones);
        check("mr_refill_beats", 64'(beats), 64'd8);
        check("mr_refill_done", 64'(dones), 64'd1);

        for (int f = 0; f < 6; f++) begin
            run_frame(2, beats, dones);
            check($sformatf("rnd%0d_beats", f), 64'(beats), 64'd8);
            check($sformatf("rnd%0d_done", f), 64'(dones), 64'd1);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
